csa_accum_sequencer: RTL and testbench

Sequencer for the 128-bit carry-save accumulation datapath. It takes a job length, accepts that many operands over a valid/ready stream, and folds each operand into carry-save state held in complemented form. It then performs the single final carry-propagate resolution and presents the sum on a held output handshake. It sits between the operand source and the consumer of resolved 128-bit sums, and owns all stage sequencing of the carry-save registers.

---
 rtl/csa_accum_sequencer.sv | 157 +++++++++++++++
 tb/tb_csa_accum_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : csa_accum_sequencer
// Purpose  : Sequences a 128-bit carry-save accumulation job. Accepts a job
//            length, folds that many operands into complemented carry-save
//            state, performs one final carry-propagate add and holds the
//            resolved sum on an output handshake until it is taken.
// Ports    : clk, reset     - clock, synchronous active-high reset
//            start, len     - job request and operand count (IDLE only)
//            in_valid/in_ready/in_data    - operand stream
//            out_valid/out_ready/out_data - resolved sum handshake
//            busy           - high whenever not IDLE
//            chk_err        - sticky shadow-check mismatch flag
// Options  : CSA_SEQ_SHADOW_CHECK_EN enables the binary shadow accumulator
//            that drives chk_err; without it chk_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module csa_accum_sequencer #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             chk_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] c_n_q, c_n_d;
  logic [WIDTH-1:0] s_n_q, s_n_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  // True-polarity views of the carry-save pair and the CSA step results.
  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_maj;
  logic [WIDTH-1:0] w_csa_sum;
  logic [WIDTH-1:0] w_csa_carry;
  logic [WIDTH-1:0] w_resolved;

  assign w_c         = ~c_n_q;
  assign w_s         = ~s_n_q;
  assign w_csa_sum   = w_s ^ w_c ^ in_data;
  assign w_maj       = (w_s & w_c) | (w_s & in_data) | (w_c & in_data);
  // Carry out of the MSB is dropped by the shift.
  assign w_csa_carry = {w_maj[WIDTH-2:0], 1'b0};
  assign w_resolved  = w_c + w_s;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    c_n_d      = c_n_q;
    s_n_d      = s_n_q;
    out_data_d = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = len;
          c_n_d   = '1;
          s_n_d   = '1;
          state_d = (len == '0) ? ST_RESOLVE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone is a handshake.
        if (in_valid) begin
          s_n_d = ~w_csa_sum;
          c_n_d = ~w_csa_carry;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_RESOLVE;
          end
        end
      end
      ST_RESOLVE: begin
        out_data_d = w_resolved;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      c_n_q      <= '1;
      s_n_q      <= '1;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      c_n_q      <= c_n_d;
      s_n_q      <= s_n_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_data_q;

`ifdef CSA_SEQ_SHADOW_CHECK_EN
  // Plain binary accumulator used to cross-check the carry-save result.
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             chk_err_q, chk_err_d;

  always_comb begin
    shadow_d  = shadow_q;
    chk_err_d = chk_err_q;
    case (state_q)
      ST_IDLE:    if (start) shadow_d = '0;
      ST_ACCUM:   if (in_valid) shadow_d = shadow_q + in_data;
      ST_RESOLVE: chk_err_d = chk_err_q | (w_resolved != shadow_q);
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q  <= '0;
      chk_err_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csa_accum_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_accum_sequencer
// Purpose  : Self-checking bench for csa_accum_sequencer. A job-level model
//            (plain binary sums and a phase per job) predicts the outputs
//            every cycle; directed jobs pin the model with literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_accum_sequencer;

  localparam int WIDTH = 128;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;
  logic             chk_err;

  always #5 clk = ~clk;

  csa_accum_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .chk_err   (chk_err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  function automatic void check(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // ---------------------------------------------------------------------------
  // Job-level model: phase 0 idle, 1 taking operands, 2 resolving, 3 holding.
  // The sum is an ordinary binary addition modulo 2^WIDTH.
  // ---------------------------------------------------------------------------
  int               m_phase = 0;
  int               m_rem   = 0;
  logic [WIDTH-1:0] m_sum   = '0;
  logic [WIDTH-1:0] m_out   = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_rem   = 0;
      m_out   = '0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_sum   = '0;
             m_rem   = int'(len);
             m_phase = (m_rem == 0) ? 2 : 1;
           end
        1: if (in_valid) begin
             m_sum = m_sum + in_data;
             m_rem = m_rem - 1;
             if (m_rem == 0) m_phase = 2;
           end
        2: begin
             m_out   = m_sum;
             m_phase = 3;
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",      WIDTH'(busy),      WIDTH'(m_phase != 0));
      check("in_ready",  WIDTH'(in_ready),  WIDTH'(m_phase == 1));
      check("out_valid", WIDTH'(out_valid), WIDTH'(m_phase == 3));
      check("out_data",  out_data,          m_out);
      check("chk_err",   WIDTH'(chk_err),   '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] ops [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_job(input int n, input bit gaps, output logic [WIDTH-1:0] got);
    logic [WIDTH-1:0] exp_sum;
    int i, guard, lat;
    bit hs;
    exp_sum = '0;
    for (int k = 0; k < n; k++) exp_sum = exp_sum + ops[k];
    guard = 0;
    while (busy && guard < 1000) begin tick(); guard++; end
    if (busy) check("idle_timeout", '0, WIDTH'(1));
    start = 1'b1;
    len   = CNT_W'(n);
    tick();
    start = 1'b0;
    len   = CNT_W'($urandom);
    i = 0;
    guard = 0;
    while (i < n && guard < 4000) begin
      in_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
      in_data  = in_valid ? ops[i] : rnd128();
      hs = in_valid && in_ready;
      tick();
      guard++;
      if (hs) i++;
    end
    in_valid = 1'b0;
    in_data  = rnd128();
    if (i < n) check("accept_timeout", WIDTH'(i), WIDTH'(n));
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    check("latency", WIDTH'(lat), WIDTH'(1));
    got = out_data;
    check("job_sum", got, exp_sum);
    guard = 0;
    hs = 1'b0;
    while (!hs && guard < 100) begin
      out_ready = gaps ? ($urandom_range(1) != 0) : 1'b1;
      hs = out_ready && out_valid;
      tick();
      guard++;
    end
    out_ready = 1'b0;
    if (!hs) check("out_timeout", '0, WIDTH'(1));
    check("post_take_busy",  WIDTH'(busy),      '0);
    check("post_take_valid", WIDTH'(out_valid), '0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] got;
    logic [WIDTH-1:0] big;
    reset     = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_busy",      WIDTH'(busy),      '0);
    check("rst_in_ready",  WIDTH'(in_ready),  '0);
    check("rst_out_valid", WIDTH'(out_valid), '0);
    check("rst_out_data",  out_data,          '0);
    check("rst_chk_err",   WIDTH'(chk_err),   '0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a job discards it.
    start = 1'b1; len = CNT_W'(4);
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = WIDTH'(7);
    tick();
    in_data = WIDTH'(9);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy",      WIDTH'(busy),      '0);
    check("midrst_in_ready",  WIDTH'(in_ready),  '0);
    check("midrst_out_valid", WIDTH'(out_valid), '0);
    ops[0] = WIDTH'(5);
    run_job(1, 1'b0, got);
    check("after_reset_5", got, WIDTH'(5));

    // Basic sum.
    ops[0] = WIDTH'(1); ops[1] = WIDTH'(2); ops[2] = WIDTH'(3);
    run_job(3, 1'b0, got);
    check("basic_6", got, WIDTH'(6));

    // Wrap-around past 2^128.
    ops[0] = '1; ops[1] = WIDTH'(2);
    run_job(2, 1'b0, got);
    check("wrap_1", got, WIDTH'(1));

    // Carry chain through the MSB.
    big = '0;
    big[WIDTH-1] = 1'b1;
    ops[0] = big; ops[1] = big; ops[2] = big;
    run_job(3, 1'b0, got);
    check("carry_2p127", got, big);

    // Empty job with backpressure; a start during the hold is ignored.
    start = 1'b1; len = '0;
    tick();
    start = 1'b0;
    check("empty_t1_valid", WIDTH'(out_valid), '0);
    tick();
    check("empty_t2_valid", WIDTH'(out_valid), WIDTH'(1));
    check("empty_t2_data",  out_data,          '0);
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      len   = CNT_W'(3);
      tick();
      check("hold_valid", WIDTH'(out_valid), WIDTH'(1));
      check("hold_data",  out_data,          '0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("empty_take_busy",  WIDTH'(busy),      '0);
    check("empty_take_valid", WIDTH'(out_valid), '0);

    // Randomized jobs with gaps on both handshakes.
    for (int j = 0; j < 200; j++) begin
      int n;
      n = $urandom_range(255);
      for (int k = 0; k < n; k++)
        ops[k] = ($urandom_range(7) == 0) ? '1 : rnd128();
      run_job(n, 1'b1, got);
    end

    tick();
    check("final_chk_err", WIDTH'(chk_err), '0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
